// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Multi-cycle sequencer for the execute-stage 32-bit logarithmic shifter.
// A single shift layer is reused across clocks: layer cnt (shift by 2^cnt) is
// applied on each SHIFT edge when amt[cnt] is set, giving SLL/SRL/SRA.
//
// Optional feature (macro SHIFT_SEQ_EARLY_EXIT_EN): leave SHIFT as soon as
// no amount bit above the current layer remains set. Results are identical
// in both builds; only the latency differs.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset (priority over everything)
//   in_valid   in   request valid
//   in_ready   out  block can accept a request (IDLE only)
//   in_op      in   00 SLL, 01 SRL, 11 SRA, 10 SLL
//   in_a       in   operand to shift
//   in_amt     in   shift amount
//   kill       in   abort any operation in flight
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   out_s      out  shifted result, held until the next result
//   busy       out  high in SHIFT or DONE
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_s,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [XLEN-1:0]  r_data;
    logic [XLEN-1:0]  r_out;
    logic [AMT_W-1:0] r_amt;
    logic [2:0]       r_cnt;
    logic             r_right;
    logic             r_sign;

    logic             w_accept;
    logic             w_last;
    logic [AMT_W-1:0] w_step;
    logic [AMT_W-1:0] w_rest;
    logic [XLEN-1:0]  w_shr;
    logic [XLEN-1:0]  w_fill;
    logic [XLEN-1:0]  w_layer;

    // A request is taken only in IDLE and only when no abort is pending.
    assign w_accept = (r_state == ST_IDLE) && in_valid && !kill;

    // Single shift layer: shift by 2^cnt when amt[cnt] is set, else hold.
    always_comb begin
        w_step  = AMT_W'(1) << r_cnt;
        w_shr   = r_data >> w_step;
        // SRA fill comes from the sign captured at accept, so it is the
        // same for every layer regardless of what the data has become.
        w_fill  = ~({XLEN{1'b1}} >> w_step);
        w_layer = r_data;
        if (r_amt[r_cnt]) begin
            if (r_right) begin
                if (r_sign) begin
                    w_layer = w_shr | w_fill;
                end else begin
                    w_layer = w_shr;
                end
            end else begin
                w_layer = r_data << w_step;
            end
        end else begin
            w_layer = r_data;
        end
    end

    // Decide whether the layer processed at this edge is the final one.
    always_comb begin
        w_rest = r_amt >> (r_cnt + 3'd1);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        // No higher amount bits left: the remaining layers would all hold.
        w_last = (r_cnt == 3'd4) || (w_rest == {AMT_W{1'b0}});
`else
        w_last = (r_cnt == 3'd4);
`endif
    end

    // Next-state logic; kill overrides every transition including delivery.
    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: operand capture, layer stepping, result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= {XLEN{1'b0}};
            r_out   <= {XLEN{1'b0}};
            r_amt   <= {AMT_W{1'b0}};
            r_cnt   <= 3'd0;
            r_right <= 1'b0;
            r_sign  <= 1'b0;
        end else if (w_accept) begin
            r_data  <= in_a;
            r_amt   <= in_amt;
            r_cnt   <= 3'd0;
            r_right <= in_op[0];
            r_sign  <= (in_op == 2'b11) && in_a[XLEN-1];
        end else if ((r_state == ST_SHIFT) && !kill) begin
            r_data <= w_layer;
            r_cnt  <= r_cnt + 3'd1;
            // The result register only changes when a new result is ready,
            // so out_s keeps the previous value through IDLE and SHIFT.
            if (w_last) begin
                r_out <= w_layer;
            end
        end
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign out_s = r_out;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Self-checking bench for shift_seq_ctrl: directed cases followed by random
// requests, compared against an arithmetic reference of the shift and of the
// expected latency (SHIFT_SEQ_EARLY_EXIT_EN selects the latency rule).
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [4:0]  in_amt;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_seq_ctrl #(.XLEN(32), .AMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference shift: plain operators on 32 bits.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [4:0] amt);
        if (op == 2'b01) return a >> amt;
        if (op == 2'b11) return 32'($signed(a) >>> amt);
        return a << amt;
    endfunction

    // Reference latency: edges from accept to out_valid.
    function automatic int ref_lat(input logic [4:0] amt);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < 5; i++) if (amt[i]) l = i + 1;
        return l;
`else
        return 5;
`endif
    endfunction

    // One request/response: accept, wait for result, hold 'hold' cycles, deliver.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] amt, input int hold);
        logic [31:0] exp_s;
        int lat;
        exp_s = ref_shift(op, a, amt);
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_amt    = amt;
        tick();
        in_valid = 1'b0;
        in_a     = $urandom;
        chk({tag, ".busy_after_accept"}, {31'd0, busy & ~in_ready}, 32'd1);
        lat = 0;
        while (lat < 20) begin
            if (out_valid) break;
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(ref_lat(amt)));
        chk({tag, ".out_s"}, out_s, exp_s);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".bp_valid"}, {30'd0, out_valid, in_ready}, 32'd2);
            chk({tag, ".bp_data"}, out_s, exp_s);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, ".delivered"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
        chk({tag, ".out_s_hold"}, out_s, exp_s);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 32'd0;
        in_amt    = 5'd0;
        kill      = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset.flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        chk("reset.out_s", out_s, 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases.
        run_op("sra_sign",   2'b11, 32'h8000_0000, 5'd4,  0);
        run_op("sll_31",     2'b00, 32'h0000_0001, 5'd31, 0);
        run_op("srl_16",     2'b01, 32'hFFFF_FFFF, 5'd16, 0);
        run_op("op10_sll",   2'b10, 32'h0000_000F, 5'd4,  0);
        run_op("amt0",       2'b01, 32'h1234_5678, 5'd0,  0);
        run_op("amt1",       2'b11, 32'hF000_0001, 5'd1,  0);
        run_op("amt3",       2'b01, 32'h8000_0000, 5'd3,  0);
        run_op("sra_pos",    2'b11, 32'h7FFF_FFFF, 5'd31, 0);
        run_op("backpress",  2'b00, 32'hA5A5_0F0F, 5'd7,  3);
        run_op("after_bp",   2'b11, 32'h9000_0000, 5'd2,  0);

        // kill in IDLE with in_valid: request must not be accepted.
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'h1; in_amt = 5'd1; kill = 1'b1;
        tick();
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_idle.flags", {29'd0, in_ready, out_valid, busy}, 32'd4);

        // kill two cycles into SHIFT: back to IDLE, no result ever.
        in_valid = 1'b1; in_op = 2'b11; in_a = 32'hDEAD_BEEF; in_amt = 5'd31;
        tick();
        in_valid = 1'b0;
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_shift.flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("kill_shift.no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op("after_kill", 2'b01, 32'h0000_0100, 5'd8, 0);

        // rst together with kill mid-SHIFT.
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'h0000_00FF; in_amt = 5'd31;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1; kill = 1'b1;
        tick();
        rst = 1'b0; kill = 1'b0;
        chk("rst_shift.flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        chk("rst_shift.out_s", out_s, 32'd0);

        // rst in DONE with out_ready=1: nothing delivered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b01; in_a = 32'hF0F0_F0F0; in_amt = 5'd4;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("rst_done.reached", {31'd0, out_valid}, 32'd1);
        chk("rst_done.data", out_s, 32'h0F0F_0F0F);
        out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_done.flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        chk("rst_done.out_s", out_s, 32'd0);
        tick();
        chk("rst_done.no_valid", {31'd0, out_valid}, 32'd0);

        // Random requests with random backpressure.
        for (int k = 0; k < 40; k++) begin
            run_op("rand", 2'($urandom_range(0, 3)), $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
